hs_rr_buffer: RTL and testbench



---
 rtl/hs_rr_buffer.sv | 126 ++++++++++++
 tb/tb_hs_rr_buffer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hs_rr_buffer.sv
// Multi-channel handshake concentrator: per-channel holding registers feed a
// round-robin arbiter that pushes one word per cycle into a tagged FIFO.
module hs_rr_buffer #(
    parameter  int WIDTH = 32,
    parameter  int CH    = 4,
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(CH),
    localparam int NW    = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CH-1:0]         sready,
    input  logic [CH*WIDTH-1:0]   din,
    output logic [CH-1:0]         sidle,
    input  logic                  dbusy,
    output logic                  dvalid,
    output logic [WIDTH-1:0]      dout,
    output logic [CW-1:0]         dchan,
    output logic [NW-1:0]         count
);

    localparam int AW = $clog2(DEPTH);
    localparam int SW = CW + 1;

    logic [CH-1:0]    pend_q, pend_d;
    logic [WIDTH-1:0] hold_q [CH];
    logic [CW-1:0]    rr_q, rr_d;

    logic [WIDTH-1:0] mem_data_q [DEPTH];
    logic [CW-1:0]    mem_chan_q [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [NW-1:0]    count_q, count_d;

    logic             pop, space, push, gnt_found;
    logic [CW-1:0]    gnt_idx;
    logic [SW-1:0]    scan;
    logic [CW-1:0]    sel;

    assign pop   = (count_q != '0) && !dbusy;
    assign space = (count_q < NW'(DEPTH)) || pop;

    // Scan pend from rr_q upward with explicit mod-CH wrap so non-power-of-two CH works.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        scan      = '0;
        sel       = '0;
        for (int unsigned k = 0; k < CH; k++) begin
            scan = {1'b0, rr_q} + SW'(k);
            if (scan >= SW'(CH)) begin
                scan = scan - SW'(CH);
            end
            sel = scan[CW-1:0];
            if (!gnt_found && pend_q[sel]) begin
                gnt_found = 1'b1;
                gnt_idx   = sel;
            end
        end
    end

    assign push = space && gnt_found;

    always_comb begin
        pend_d = pend_q;
        rr_d   = rr_q;
        if (push) begin
            pend_d[gnt_idx] = 1'b0;
            rr_d = (gnt_idx == CW'(CH - 1)) ? '0 : gnt_idx + CW'(1);
        end
        for (int unsigned i = 0; i < CH; i++) begin
            if (!pend_q[i] && sready[i]) begin
                pend_d[i] = 1'b1;
            end
        end
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + NW'(1);
            2'b01:   count_d = count_q - NW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q  <= '0;
            rr_q    <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            for (int unsigned i = 0; i < CH; i++) begin
                hold_q[i] <= '0;
            end
            for (int unsigned d = 0; d < DEPTH; d++) begin
                mem_data_q[d] <= '0;
                mem_chan_q[d] <= '0;
            end
        end else begin
            pend_q  <= pend_d;
            rr_q    <= rr_d;
            count_q <= count_d;
            for (int unsigned i = 0; i < CH; i++) begin
                if (!pend_q[i] && sready[i]) begin
                    hold_q[i] <= din[i*WIDTH +: WIDTH];
                end
            end
            if (push) begin
                mem_data_q[wptr_q] <= hold_q[gnt_idx];
                mem_chan_q[wptr_q] <= gnt_idx;
                wptr_q             <= wptr_q + AW'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + AW'(1);
            end
        end
    end

    assign sidle  = ~pend_q;
    assign dvalid = (count_q != '0);
    assign dout   = mem_data_q[rptr_q];
    assign dchan  = mem_chan_q[rptr_q];
    assign count  = count_q;

endmodule

// File: tb/tb_hs_rr_buffer.sv
// Scoreboard bench for hs_rr_buffer: a queue-based reference model predicts
// each delivered word; a negedge monitor compares on every pop.
module tb_hs_rr_buffer;

    localparam int WIDTH = 32;
    localparam int CH    = 4;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(CH);
    localparam int NW    = $clog2(DEPTH + 1);

    logic                clk = 1'b0;
    logic                rst;
    logic [CH-1:0]       sready;
    logic [CH*WIDTH-1:0] din;
    logic [CH-1:0]       sidle;
    logic                dbusy;
    logic                dvalid;
    logic [WIDTH-1:0]    dout;
    logic [CW-1:0]       dchan;
    logic [NW-1:0]       count;

    hs_rr_buffer #(.WIDTH(WIDTH), .CH(CH), .DEPTH(DEPTH)) dut (
        .clk    (clk),
        .rst    (rst),
        .sready (sready),
        .din    (din),
        .sidle  (sidle),
        .dbusy  (dbusy),
        .dvalid (dvalid),
        .dout   (dout),
        .dchan  (dchan),
        .count  (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          chan;
        logic [31:0] data;
    } ent_t;

    int tests  = 0;
    int errors = 0;

    // Reference model: pending words per channel, FIFO as a queue.
    bit          m_pend [CH];
    bit          m_old  [CH];
    logic [31:0] m_hold [CH];
    int          m_rr;
    ent_t        m_fifo [$];
    ent_t        sb_q   [$];
    int          out_log [$];
    bit          model_ok = 1'b0;
    ent_t        model_e, mon_e;
    int          g;
    bit          m_pop, m_space;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CH; i++) begin
                m_pend[i] = 1'b0;
                m_hold[i] = '0;
            end
            m_rr = 0;
            m_fifo.delete();
            sb_q.delete();
            model_ok = 1'b1;
        end else if (model_ok) begin
            m_old   = m_pend;
            m_pop   = (m_fifo.size() > 0) && !dbusy;
            m_space = (m_fifo.size() < DEPTH) || m_pop;
            g = -1;
            if (m_space) begin
                for (int k = 0; k < CH; k++) begin
                    if (g < 0 && m_old[(m_rr + k) % CH]) g = (m_rr + k) % CH;
                end
            end
            if (m_pop) void'(m_fifo.pop_front());
            if (g >= 0) begin
                model_e.chan = g;
                model_e.data = m_hold[g];
                m_fifo.push_back(model_e);
                sb_q.push_back(model_e);
                m_pend[g] = 1'b0;
                m_rr = (g + 1) % CH;
            end
            for (int i = 0; i < CH; i++) begin
                if (!m_old[i] && sready[i]) begin
                    m_pend[i] = 1'b1;
                    m_hold[i] = din[i*WIDTH +: WIDTH];
                end
            end
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            logic [CH-1:0] es;
            for (int i = 0; i < CH; i++) es[i] = !m_pend[i];
            chk("dvalid", dvalid, m_fifo.size() != 0);
            chk("count", count, m_fifo.size());
            chk("sidle", sidle, es);
            if (dvalid && !dbusy && !rst) begin
                if (sb_q.size() == 0) begin
                    tests++;
                    errors++;
                    $display("FAIL unexpected_pop: got dchan %0d dout %0h expected no word (t=%0t)",
                             dchan, dout, $time);
                end else begin
                    mon_e = sb_q.pop_front();
                    chk("dout", dout, mon_e.data);
                    chk("dchan", dchan, mon_e.chan);
                    out_log.push_back(int'(dchan));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_count(input int n);
        int cyc = 0;
        while (int'(count) != n && cyc < 50) begin
            tick();
            cyc++;
        end
        chk("wait_count", count, n);
    endtask

    task automatic wait_drained();
        int cyc = 0;
        while ((count != '0 || sidle != '1) && cyc < 100) begin
            tick();
            cyc++;
        end
        chk("drain_count", count, 0);
        chk("drain_sidle", sidle, {CH{1'b1}});
    endtask

    task automatic scenario1();
        din[0 +: WIDTH] = 32'hA5A5_0001;
        sready = 4'b0001;
        tick();
        sready = '0;
        tick();
        chk("s1_dvalid", dvalid, 1);
        chk("s1_dout", dout, 32'hA5A5_0001);
        chk("s1_dchan", dchan, 0);
        chk("s1_sidle0", sidle[0], 1);
        tick();
        chk("s1_count", count, 0);
    endtask

    task automatic burst_all();
        for (int i = 0; i < CH; i++) din[i*WIDTH +: WIDTH] = 32'(i + 1);
        sready = '1;
        tick();
        sready = '0;
    endtask

    int n0, n2;

    initial begin
        rst = 1'b1; sready = '0; din = '0; dbusy = 1'b0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_dvalid", dvalid, 0);
        chk("rst_count", count, 0);
        chk("rst_sidle", sidle, 4'b1111);
        chk("rst_dout", dout, 0);
        chk("rst_dchan", dchan, 0);

        scenario1();

        // Two back-to-back simultaneous bursts from a fresh rr pointer.
        rst = 1'b1; tick(); rst = 1'b0;
        out_log.delete();
        burst_all();
        wait_drained();
        burst_all();
        wait_drained();
        chk("s2_nwords", out_log.size(), 8);
        for (int i = 0; i < 8 && i < out_log.size(); i++) chk("s2_order", out_log[i], i % CH);

        // Overfill under stall, then release.
        out_log.delete();
        dbusy = 1'b1;
        burst_all();
        wait_count(4);
        for (int i = 0; i < 2; i++) din[i*WIDTH +: WIDTH] = 32'hBEEF_0000 + 32'(i);
        sready = 4'b0011;
        tick();
        sready = '0;
        tick(); tick();
        chk("s3_full", count, 4);
        chk("s3_blocked", sidle, 4'b1100);
        dbusy = 1'b0;
        wait_drained();
        chk("s3_nwords", out_log.size(), 6);

        // Full FIFO, one pending channel, push and pop on the same edge.
        dbusy = 1'b1;
        burst_all();
        wait_count(4);
        din[2*WIDTH +: WIDTH] = 32'hC0DE_0002;
        sready = 4'b0100;
        tick();
        sready = '0;
        tick();
        chk("s4_hold_sidle", sidle, 4'b1011);
        chk("s4_hold_count", count, 4);
        dbusy = 1'b0;
        tick();
        chk("s4_pp_count", count, 4);
        chk("s4_pp_sidle2", sidle[2], 1);
        wait_drained();

        // Continuous offers on channels 0 and 2 must alternate.
        out_log.delete();
        for (int c = 0; c < 16; c++) begin
            din[0 +: WIDTH]       = $urandom;
            din[2*WIDTH +: WIDTH] = $urandom;
            sready = 4'b0101;
            tick();
        end
        sready = '0;
        wait_drained();
        n0 = 0; n2 = 0;
        foreach (out_log[i]) begin
            if (out_log[i] == 0) n0++;
            if (out_log[i] == 2) n2++;
        end
        chk("s5_ch0_served", n0 >= 5, 1);
        chk("s5_ch2_served", n2 >= 5, 1);

        // Reset with occupied FIFO and pending words.
        dbusy = 1'b1;
        sready = 4'b0111;
        tick();
        sready = '0;
        wait_count(3);
        sready = 4'b0011;
        tick();
        sready = '0;
        chk("s6_pre_count", count, 3);
        chk("s6_pre_sidle", sidle, 4'b1100);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        dbusy = 1'b0;
        chk("s6_dvalid", dvalid, 0);
        chk("s6_count", count, 0);
        chk("s6_sidle", sidle, 4'b1111);
        chk("s6_dout", dout, 0);
        chk("s6_dchan", dchan, 0);
        scenario1();

        // Random traffic with occasional stalls and rare resets.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < CH; i++) din[i*WIDTH +: WIDTH] = $urandom;
            sready = 4'($urandom);
            dbusy  = ($urandom_range(0, 9) < 3);
            rst    = ($urandom_range(0, 599) == 0);
            tick();
        end
        rst = 1'b0; sready = '0; dbusy = 1'b0;
        wait_drained();
        chk("sb_leftover", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
